// File: rtl/apb_led_pwm_pkg.sv
// ============================================================================
// Module      : apb_led_pwm_pkg
// Description : Register map, FSM encoding and decode helper for the APB LED
//               PWM responder.
// Revision    : 1.0
// ============================================================================
`default_nettype none

package apb_led_pwm_pkg;

   localparam logic [5:0] OFS_CTRL     = 6'h00;
   localparam logic [5:0] OFS_PRESCALE = 6'h04;
   localparam logic [5:0] OFS_STATUS   = 6'h08;
   localparam logic [5:0] OFS_SCRATCH  = 6'h0C;
   localparam logic [5:0] OFS_DUTY0    = 6'h10;
   localparam logic [5:0] OFS_LAST     = 6'h2C;

   localparam int CTRL_EN     = 0;
   localparam int CTRL_INV    = 1;
   localparam int STATUS_SW   = 0;
   localparam int STATUS_EDGE = 1;

   typedef logic [0:0] state_t;
   localparam state_t S_IDLE = 1'b0;
   localparam state_t S_RD   = 1'b1;

   // Misaligned or beyond the last duty register
   function automatic logic addr_err(input logic [5:0] ofs);
      return (ofs[1:0] != 2'b00) || (ofs > OFS_LAST);
   endfunction

endpackage

`default_nettype wire

// File: rtl/apb_led_pwm_slave_if.sv
// ============================================================================
// Module      : apb_led_pwm_slave_if
// Description : APB3 bus bundle between the SoC initiator and the LED PWM
//               responder.
// Revision    : 1.0
// ============================================================================
`default_nettype none

interface apb_led_pwm_slave_if #(
   parameter int ADDR_W = 16
) ();

   logic [ADDR_W-1:0] paddr;
   logic              psel;
   logic              penable;
   logic              pwrite;
   logic [31:0]       pwdata;
   logic [31:0]       prdata;
   logic              pready;
   logic              pslverror;

   modport master (
      output paddr, psel, penable, pwrite, pwdata,
      input  prdata, pready, pslverror
   );

   modport slave (
      input  paddr, psel, penable, pwrite, pwdata,
      output prdata, pready, pslverror
   );

endinterface

`default_nettype wire

// File: rtl/apb_led_pwm_slave_pwm_timebase.sv
// ============================================================================
// Module      : pwm_timebase
// Description : Programmable prescaler producing a tick that advances the
//               free-running 8-bit PWM counter.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module pwm_timebase
   import apb_led_pwm_pkg::*;
(
   input  wire logic        clk,
   input  wire logic        rst_n,
   input  wire logic [15:0] prescale,
   input  wire logic        reload,
   output logic [7:0]       pwm_cnt
);

   logic [15:0] presc_cnt;
   logic        tick;

   // A reload restarts the prescale period, so it never also ticks
   assign tick = !reload && (presc_cnt >= prescale);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         presc_cnt <= '0;
         pwm_cnt   <= '0;
      end else if (reload) begin
         presc_cnt <= '0;
      end else if (tick) begin
         presc_cnt <= '0;
         pwm_cnt   <= pwm_cnt + 8'd1;
      end else begin
         presc_cnt <= presc_cnt + 16'd1;
      end
   end

endmodule

`default_nettype wire

// File: rtl/apb_led_pwm_slave.sv
// ============================================================================
// Module      : apb_led_pwm_slave
// Description : APB3 responder with control/prescale/status/scratch/duty
//               registers, eight PWM LED outputs and a synchronised switch.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module apb_led_pwm_slave
   import apb_led_pwm_pkg::*;
#(
   parameter int          ADDR_W       = 16,
   parameter logic [15:0] PRESCALE_RST = 16'd99,
   parameter int          LED_N        = 8
) (
   input  wire logic          io_systemClk,
   input  wire logic          io_asyncResetn,
   apb_led_pwm_slave_if.slave io_apbSlave_0,
   output logic [LED_N-1:0]   o_led,
   input  wire logic          i_sw
);

   state_t      state;
   state_t      state_nxt;

   logic [1:0]  ctrl;
   logic [15:0] prescale;
   logic [31:0] scratch;
   logic [7:0]  duty [LED_N];
   logic        edge_flag;

   logic        sw_meta;
   logic        sw_s;
   logic        sw_d;
   logic        sw_rise;

   logic [31:0] rd_data_q;
   logic        rd_err_q;
   logic [31:0] rd_mux;

   logic [5:0]  ofs;
   logic [2:0]  duty_idx;
   logic        err;
   logic        is_duty;
   logic        access;
   logic        wr_acc;
   logic        rd_acc;
   logic        wr_en;
   logic [7:0]  pwm_cnt;

   assign ofs      = io_apbSlave_0.paddr[5:0];
   assign err      = addr_err(ofs);
   assign is_duty  = (ofs >= OFS_DUTY0) && !err;
   assign duty_idx = 3'(ofs[5:2] - 4'd4);
   assign access   = io_apbSlave_0.psel && io_apbSlave_0.penable;
   assign wr_acc   = (state == S_IDLE) && access && io_apbSlave_0.pwrite;
   assign rd_acc   = (state == S_IDLE) && access && !io_apbSlave_0.pwrite;
   assign wr_en    = wr_acc && !err;

   // ---------------------------------------------------------------- FSM
   always_ff @(posedge io_systemClk or negedge io_asyncResetn) begin
      if (!io_asyncResetn) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:  if (rd_acc) state_nxt = S_RD;
         S_RD:    state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   // Writes finish combinationally; gating with reset keeps PREADY low while
   // reset is held even if the initiator keeps an access phase up.
   always_comb begin
      io_apbSlave_0.pready    = 1'b0;
      io_apbSlave_0.pslverror = 1'b0;
      io_apbSlave_0.prdata    = '0;
      case (state)
         S_IDLE: begin
            if (wr_acc && io_asyncResetn) begin
               io_apbSlave_0.pready    = 1'b1;
               io_apbSlave_0.pslverror = err;
            end
         end
         S_RD: begin
            io_apbSlave_0.prdata = rd_data_q;
            if (io_apbSlave_0.psel) begin
               io_apbSlave_0.pready    = 1'b1;
               io_apbSlave_0.pslverror = rd_err_q;
            end
         end
         default: ;
      endcase
   end

   // ---------------------------------------------------------------- read path
   always_comb begin
      rd_mux = '0;
      case (ofs)
         OFS_CTRL:     rd_mux = {30'd0, ctrl};
         OFS_PRESCALE: rd_mux = {16'd0, prescale};
         OFS_STATUS:   rd_mux = {30'd0, edge_flag, sw_s};
         OFS_SCRATCH:  rd_mux = scratch;
         default:      if (is_duty) rd_mux = {24'd0, duty[duty_idx]};
      endcase
   end

   always_ff @(posedge io_systemClk or negedge io_asyncResetn) begin
      if (!io_asyncResetn) begin
         rd_data_q <= '0;
         rd_err_q  <= 1'b0;
      end else if (rd_acc) begin
         rd_data_q <= err ? 32'd0 : rd_mux;
         rd_err_q  <= err;
      end
   end

   // ---------------------------------------------------------------- registers
   always_ff @(posedge io_systemClk or negedge io_asyncResetn) begin
      if (!io_asyncResetn) begin
         ctrl     <= '0;
         prescale <= PRESCALE_RST;
         scratch  <= '0;
         for (int i = 0; i < LED_N; i++) duty[i] <= '0;
      end else if (wr_en) begin
         case (ofs)
            OFS_CTRL:     ctrl     <= io_apbSlave_0.pwdata[1:0];
            OFS_PRESCALE: prescale <= io_apbSlave_0.pwdata[15:0];
            OFS_SCRATCH:  scratch  <= io_apbSlave_0.pwdata;
            default:      if (is_duty) duty[duty_idx] <= io_apbSlave_0.pwdata[7:0];
         endcase
      end
   end

   // ---------------------------------------------------------------- switch
   assign sw_rise = sw_s && !sw_d;

   always_ff @(posedge io_systemClk or negedge io_asyncResetn) begin
      if (!io_asyncResetn) begin
         sw_meta   <= 1'b0;
         sw_s      <= 1'b0;
         sw_d      <= 1'b0;
         edge_flag <= 1'b0;
      end else begin
         sw_meta <= i_sw;
         sw_s    <= sw_meta;
         sw_d    <= sw_s;
         // A new edge beats a simultaneous W1C
         if (sw_rise) begin
            edge_flag <= 1'b1;
         end else if (wr_en && (ofs == OFS_STATUS) && io_apbSlave_0.pwdata[STATUS_EDGE]) begin
            edge_flag <= 1'b0;
         end
      end
   end

   // ---------------------------------------------------------------- PWM
   pwm_timebase u_timebase (
      .clk      (io_systemClk),
      .rst_n    (io_asyncResetn),
      .prescale (prescale),
      .reload   (wr_en && (ofs == OFS_PRESCALE)),
      .pwm_cnt  (pwm_cnt)
   );

   always_ff @(posedge io_systemClk or negedge io_asyncResetn) begin
      if (!io_asyncResetn) begin
         o_led <= '0;
      end else begin
         for (int i = 0; i < LED_N; i++) begin
            o_led[i] <= ctrl[CTRL_EN] ? ((pwm_cnt < duty[i]) ^ ctrl[CTRL_INV]) : 1'b0;
         end
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_apb_led_pwm_slave.sv
// ============================================================================
// Module      : tb_apb_led_pwm_slave
// Description : Self-checking bench for apb_led_pwm_slave with a behavioural
//               register/PWM reference model and randomized APB traffic.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_apb_led_pwm_slave;

   logic       clk;
   logic       rst_n;
   logic       sw;
   logic [7:0] led;

   int checks   = 0;
   int failures = 0;

   apb_led_pwm_slave_if #(.ADDR_W(16)) bus ();

   apb_led_pwm_slave #(
      .ADDR_W       (16),
      .PRESCALE_RST (16'd99),
      .LED_N        (8)
   ) dut (
      .io_systemClk   (clk),
      .io_asyncResetn (rst_n),
      .io_apbSlave_0  (bus),
      .o_led          (led),
      .i_sw           (sw)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=0x%08h exp=0x%08h @%0t", tag, got, exp, $time);
      end
   endtask

   // ------------------------------------------------------------ reference model
   logic [1:0]  m_ctrl;
   logic [15:0] m_presc;
   logic [31:0] m_scratch;
   logic [7:0]  m_duty [8];
   int          m_phase;
   int          m_pwm;
   logic [7:0]  m_led;

   function automatic bit bad_addr(input logic [15:0] a);
      return (a[1:0] != 2'b00) || (a[5:0] > 6'h2C);
   endfunction

   function automatic logic [31:0] m_read(input logic [15:0] a);
      int o;
      o = int'(a[5:0]);
      if (bad_addr(a)) return 32'd0;
      if (o == 0)  return {30'd0, m_ctrl};
      if (o == 4)  return {16'd0, m_presc};
      if (o == 12) return m_scratch;
      if (o >= 16) return {24'd0, m_duty[(o - 16) / 4]};
      return 32'd0;
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_ctrl    = 2'd0;
         m_presc   = 16'd99;
         m_scratch = 32'd0;
         for (int i = 0; i < 8; i++) m_duty[i] = 8'd0;
         m_phase   = 0;
         m_pwm     = 0;
         m_led     = 8'd0;
      end else begin
         bit reload;
         int old_presc;
         int o;
         for (int i = 0; i < 8; i++)
            m_led[i] = m_ctrl[0] ? ((m_pwm < int'(m_duty[i])) != m_ctrl[1]) : 1'b0;
         old_presc = int'(m_presc);
         reload    = 1'b0;
         if (bus.psel && bus.penable && bus.pwrite && !bad_addr(bus.paddr)) begin
            o = int'(bus.paddr[5:0]);
            if (o == 0)       m_ctrl    = bus.pwdata[1:0];
            else if (o == 4)  begin m_presc = bus.pwdata[15:0]; reload = 1'b1; end
            else if (o == 12) m_scratch = bus.pwdata;
            else if (o >= 16) m_duty[(o - 16) / 4] = bus.pwdata[7:0];
         end
         if (reload) m_phase = 0;
         else if (m_phase >= old_presc) begin
            m_phase = 0;
            m_pwm   = (m_pwm + 1) % 256;
         end else m_phase++;
      end
   end

   always @(negedge clk) check_eq("led", {24'd0, led}, {24'd0, m_led});

   // ------------------------------------------------------------ bus tasks
   task automatic bus_idle();
      bus.psel    = 1'b0;
      bus.penable = 1'b0;
      bus.pwrite  = 1'b0;
   endtask

   task automatic apb_wr(input logic [15:0] a, input logic [31:0] d);
      @(negedge clk);
      bus.psel = 1'b1; bus.penable = 1'b0; bus.pwrite = 1'b1;
      bus.paddr = a; bus.pwdata = d;
      @(negedge clk);
      bus.penable = 1'b1;
      #1;
      check_eq("wr_ready", {31'd0, bus.pready}, 32'd1);
      check_eq("wr_err", {31'd0, bus.pslverror}, {31'd0, bad_addr(a)});
      if (bad_addr(a)) check_eq("wr_err_data", bus.prdata, 32'd0);
      @(negedge clk);
      bus_idle();
   endtask

   task automatic apb_rd(input logic [15:0] a, input logic [31:0] exp_d, input logic exp_e);
      @(negedge clk);
      bus.psel = 1'b1; bus.penable = 1'b0; bus.pwrite = 1'b0; bus.paddr = a;
      @(negedge clk);
      bus.penable = 1'b1;
      #1;
      check_eq("rd_wait", {31'd0, bus.pready}, 32'd0);
      @(negedge clk);
      #1;
      check_eq("rd_ready", {31'd0, bus.pready}, 32'd1);
      check_eq("rd_data", bus.prdata, exp_d);
      check_eq("rd_err", {31'd0, bus.pslverror}, {31'd0, exp_e});
      @(negedge clk);
      bus_idle();
   endtask

   int hi [8];

   task automatic count_high(input int n);
      for (int i = 0; i < 8; i++) hi[i] = 0;
      for (int c = 0; c < n; c++) begin
         @(negedge clk);
         for (int i = 0; i < 8; i++) if (led[i]) hi[i]++;
      end
   endtask

   // ------------------------------------------------------------ stimulus
   initial begin
      logic [15:0] a;
      logic [31:0] d;
      int          sel;

      rst_n = 1'b0;
      sw    = 1'b0;
      bus.paddr  = '0;
      bus.pwdata = '0;
      bus_idle();
      repeat (3) @(negedge clk);
      check_eq("rst_pready", {31'd0, bus.pready}, 32'd0);
      check_eq("rst_perr", {31'd0, bus.pslverror}, 32'd0);
      check_eq("rst_prdata", bus.prdata, 32'd0);
      check_eq("rst_led", {24'd0, led}, 32'd0);
      rst_n = 1'b1;

      apb_rd(16'h0000, 32'd0, 1'b0);
      apb_rd(16'h0004, 32'd99, 1'b0);

      // scratch round trip and error responses
      apb_wr(16'h000C, 32'hDEADBEEF);
      apb_rd(16'h000C, 32'hDEADBEEF, 1'b0);
      apb_rd(16'h0030, 32'd0, 1'b1);
      apb_wr(16'h0006, 32'h12345678);
      apb_rd(16'h000C, 32'hDEADBEEF, 1'b0);
      apb_rd(16'hA00C, 32'hDEADBEEF, 1'b0);

      // duty-cycle counts at full speed
      apb_wr(16'h0004, 32'd0);
      apb_wr(16'h0010, 32'd64);
      apb_wr(16'h0014, 32'd0);
      apb_wr(16'h002C, 32'd255);
      apb_wr(16'h0000, 32'd1);
      count_high(256);
      check_eq("duty0_hi", hi[0], 32'd64);
      check_eq("duty1_hi", hi[1], 32'd0);
      check_eq("duty7_hi", hi[7], 32'd255);
      apb_wr(16'h0000, 32'd3);
      count_high(256);
      check_eq("inv_duty0_hi", hi[0], 32'd192);
      check_eq("inv_duty1_hi", hi[1], 32'd256);
      check_eq("inv_duty7_hi", hi[7], 32'd1);

      // prescaled: counter advances every 4 cycles
      apb_wr(16'h0000, 32'd1);
      apb_wr(16'h0004, 32'd3);
      count_high(1024);
      check_eq("presc3_hi", hi[0], 32'd256);
      repeat (5) @(negedge clk);
      apb_wr(16'h0004, 32'd3);
      repeat (37) @(negedge clk);

      // switch synchroniser and sticky edge flag
      @(negedge clk); sw = 1'b1;
      repeat (3) @(negedge clk);
      apb_rd(16'h0008, 32'd3, 1'b0);
      apb_wr(16'h0008, 32'd2);
      apb_rd(16'h0008, 32'd1, 1'b0);
      sw = 1'b0;
      repeat (4) @(negedge clk);
      apb_wr(16'h0008, 32'd2);
      apb_rd(16'h0008, 32'd0, 1'b0);
      // edge reaches the flag on the same edge as the W1C write
      @(negedge clk); sw = 1'b1;
      @(negedge clk);
      bus.psel = 1'b1; bus.penable = 1'b0; bus.pwrite = 1'b1;
      bus.paddr = 16'h0008; bus.pwdata = 32'd2;
      @(negedge clk);
      bus.penable = 1'b1;
      @(negedge clk);
      bus_idle();
      apb_rd(16'h0008, 32'd3, 1'b0);

      // randomized traffic against the model
      for (int n = 0; n < 300; n++) begin
         sel = int'($urandom_range(0, 9));
         case (sel)
            0, 1, 2, 3: begin
               a = {$urandom_range(0, 255) == 0 ? 10'h3FF : 10'd0, 6'(4 * $urandom_range(0, 11))};
               if (a[5:0] == 6'h08) a = 16'h000C;
               d = $urandom();
               if (a[5:0] == 6'h04) d = 32'($urandom_range(0, 5));
               apb_wr(a, d);
            end
            4, 5, 6: begin
               a = {10'($urandom()), 6'(4 * $urandom_range(0, 11))};
               if (a[5:0] == 6'h08) a[5:0] = 6'h00;
               apb_rd(a, m_read(a), 1'b0);
            end
            7: begin
               a = 16'($urandom());
               if (!bad_addr(a)) a[0] = 1'b1;
               if ($urandom_range(0, 1) == 1) apb_rd(a, 32'd0, 1'b1);
               else apb_wr(a, $urandom());
            end
            default: repeat ($urandom_range(1, 20)) @(negedge clk);
         endcase
      end

      // reset in the middle of a read
      apb_wr(16'h0004, 32'd0);
      apb_wr(16'h0010, 32'd255);
      apb_wr(16'h0000, 32'd1);
      repeat (4) @(negedge clk);
      @(negedge clk);
      bus.psel = 1'b1; bus.penable = 1'b0; bus.pwrite = 1'b0; bus.paddr = 16'h000C;
      @(negedge clk);
      bus.penable = 1'b1;
      @(negedge clk);
      #1;
      check_eq("mid_rd_ready", {31'd0, bus.pready}, 32'd1);
      rst_n = 1'b0;
      #1;
      check_eq("mid_rst_pready", {31'd0, bus.pready}, 32'd0);
      check_eq("mid_rst_prdata", bus.prdata, 32'd0);
      check_eq("mid_rst_led", {24'd0, led}, 32'd0);
      @(negedge clk);
      bus_idle();
      @(negedge clk);
      rst_n = 1'b1;
      apb_rd(16'h0000, 32'd0, 1'b0);
      apb_rd(16'h0004, 32'd99, 1'b0);

      repeat (4) @(negedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

`default_nettype wire
